// File: rtl/ofmap_storer.sv
// Output-map storer: reads output-SRAM words, issues one DMA write command,
// and streams each word as 32-bit beats (LS slice first) to the DMA.
module ofmap_storer #(
  parameter int unsigned AXI_WIDTH_AD     = 32,
  parameter int unsigned AXI_WIDTH_DA     = 32,
  parameter int unsigned BITS_TRANS       = 18,
  parameter int unsigned OUT_SRAM_ADDRESS = 5,
  parameter int unsigned DIN_WIDTH        = 16*8
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        ap_start,
  output logic                        ap_done,
  input  logic [OUT_SRAM_ADDRESS:0]   num_words,
  input  logic [8:0]                  dst_idx,
  input  logic [AXI_WIDTH_DA-1:0]     dst_base_addr,
  output logic                        r_en,
  output logic [OUT_SRAM_ADDRESS-1:0] r_addr,
  input  logic [DIN_WIDTH-1:0]        r_data,
  output logic                        start_dma,
  output logic [BITS_TRANS-1:0]       num_trans,
  output logic [AXI_WIDTH_AD-1:0]     start_addr,
  output logic [AXI_WIDTH_DA-1:0]     wr_data,
  output logic                        wr_vld,
  input  logic                        wr_rdy,
  input  logic                        done_i
);

  localparam int unsigned BEATS = DIN_WIDTH / AXI_WIDTH_DA;
  localparam int unsigned BeatW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned CntW  = OUT_SRAM_ADDRESS + 1;

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StSend, StDmaWait} state_e;

  state_e                   state_q, state_d;
  logic [CntW-1:0]          num_words_q, num_words_d;
  logic [CntW-1:0]          word_cnt_q, word_cnt_d;
  logic [BeatW-1:0]         beat_cnt_q, beat_cnt_d;
  logic [DIN_WIDTH-1:0]     shift_q, shift_d;
  logic                     sticky_q, sticky_d;
  logic                     start_dma_q, start_dma_d;
  logic                     ap_done_q, ap_done_d;
  logic [BITS_TRANS-1:0]    num_trans_q, num_trans_d;
  logic [AXI_WIDTH_AD-1:0]  start_addr_q, start_addr_d;
  logic [AXI_WIDTH_AD-1:0]  addr_off;
  logic                     beat_last;
  logic                     words_left;

  // Offset wraps modulo the address width by construction.
  assign addr_off = AXI_WIDTH_AD'(4 * BEATS) * AXI_WIDTH_AD'(num_words) *
                    AXI_WIDTH_AD'(dst_idx);
  assign beat_last  = (beat_cnt_q == BeatW'(BEATS - 1));
  assign words_left = ((word_cnt_q + CntW'(1)) < num_words_q);

  always_comb begin
    state_d      = state_q;
    num_words_d  = num_words_q;
    word_cnt_d   = word_cnt_q;
    beat_cnt_d   = beat_cnt_q;
    shift_d      = shift_q;
    sticky_d     = sticky_q;
    start_dma_d  = 1'b0;
    ap_done_d    = 1'b0;
    num_trans_d  = num_trans_q;
    start_addr_d = start_addr_q;

    // DMA completion may arrive before the last beat leaves; remember it.
    if ((state_q == StFetch || state_q == StWait || state_q == StSend) && done_i) begin
      sticky_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        sticky_d = 1'b0;
        if (ap_start) begin
          if (num_words != '0) begin
            num_words_d  = num_words;
            word_cnt_d   = '0;
            beat_cnt_d   = '0;
            start_dma_d  = 1'b1;
            num_trans_d  = BITS_TRANS'(num_words) * BITS_TRANS'(BEATS);
            start_addr_d = AXI_WIDTH_AD'(dst_base_addr) + addr_off;
            state_d      = StFetch;
          end else begin
            ap_done_d = 1'b1;
          end
        end
      end
      StFetch: state_d = StWait;
      StWait: begin
        shift_d    = r_data;
        beat_cnt_d = '0;
        state_d    = StSend;
      end
      StSend: begin
        if (wr_rdy) begin
          shift_d    = shift_q >> AXI_WIDTH_DA;
          beat_cnt_d = beat_cnt_q + BeatW'(1);
          if (beat_last) begin
            beat_cnt_d = '0;
            word_cnt_d = word_cnt_q + CntW'(1);
            state_d    = words_left ? StFetch : StDmaWait;
          end
        end
      end
      StDmaWait: begin
        if (done_i || sticky_q) begin
          ap_done_d = 1'b1;
          sticky_d  = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      num_words_q  <= '0;
      word_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      shift_q      <= '0;
      sticky_q     <= 1'b0;
      start_dma_q  <= 1'b0;
      ap_done_q    <= 1'b0;
      num_trans_q  <= '0;
      start_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      num_words_q  <= num_words_d;
      word_cnt_q   <= word_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      shift_q      <= shift_d;
      sticky_q     <= sticky_d;
      start_dma_q  <= start_dma_d;
      ap_done_q    <= ap_done_d;
      num_trans_q  <= num_trans_d;
      start_addr_q <= start_addr_d;
    end
  end

  assign ap_done    = ap_done_q;
  assign start_dma  = start_dma_q;
  assign num_trans  = num_trans_q;
  assign start_addr = start_addr_q;
  assign r_en       = (state_q == StFetch);
  assign r_addr     = word_cnt_q[OUT_SRAM_ADDRESS-1:0];
  assign wr_vld     = (state_q == StSend);
  assign wr_data    = shift_q[AXI_WIDTH_DA-1:0];

endmodule

// File: tb/tb_ofmap_storer.sv
// Scoreboard bench for ofmap_storer: stimulus queues expected commands, SRAM
// reads and beats; a negedge monitor pops and compares as the DUT presents them.
module tb_ofmap_storer;

  logic         clk = 1'b0;
  logic         rstn;
  logic         ap_start;
  logic         ap_done;
  logic [5:0]   num_words;
  logic [8:0]   dst_idx;
  logic [31:0]  dst_base_addr;
  logic         r_en;
  logic [4:0]   r_addr;
  logic [127:0] r_data;
  logic         start_dma;
  logic [17:0]  num_trans;
  logic [31:0]  start_addr;
  logic [31:0]  wr_data;
  logic         wr_vld;
  logic         wr_rdy;
  logic         done_i;

  ofmap_storer dut (
    .clk(clk), .rstn(rstn), .ap_start(ap_start), .ap_done(ap_done),
    .num_words(num_words), .dst_idx(dst_idx), .dst_base_addr(dst_base_addr),
    .r_en(r_en), .r_addr(r_addr), .r_data(r_data),
    .start_dma(start_dma), .num_trans(num_trans), .start_addr(start_addr),
    .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy), .done_i(done_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int done_seen = 0;
  int exp_done = 0;
  logic [31:0]  exp_beats[$];
  logic [4:0]   exp_raddr[$];
  logic [49:0]  exp_cmd[$];
  logic [127:0] mem[32];
  logic         stall_prev = 1'b0;
  logic         rdy_toggle = 1'b0;
  logic [3:0]   rdy_pat = 4'b1001;
  int           rdy_i = 0;

  function automatic logic [31:0] slice(input int w, input int b);
    return 32'hC0DE0000 | 32'(w << 8) | 32'(b);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL unexpected %s: got 1 expected 0", name);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " ap_done"}, ap_done, 0);
    chk({tag, " r_en"}, r_en, 0);
    chk({tag, " r_addr"}, r_addr, 0);
    chk({tag, " start_dma"}, start_dma, 0);
    chk({tag, " num_trans"}, num_trans, 0);
    chk({tag, " start_addr"}, start_addr, 0);
    chk({tag, " wr_vld"}, wr_vld, 0);
    chk({tag, " wr_data"}, wr_data, 0);
  endtask

  // SRAM model: one-cycle read latency.
  always @(posedge clk) if (r_en) r_data <= mem[r_addr];

  initial begin
    wr_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_toggle) begin
        wr_rdy = rdy_pat[rdy_i];
        rdy_i  = (rdy_i + 1) % 4;
      end else begin
        wr_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (!rstn) begin
      stall_prev = 1'b0;
    end else begin
      if (wr_vld && wr_rdy) begin
        if (exp_beats.size() == 0) unexpected("wr beat");
        else chk("wr beat", wr_data, exp_beats.pop_front());
      end else if (wr_vld && exp_beats.size() != 0) begin
        chk("stall data", wr_data, exp_beats[0]);
      end
      if (stall_prev) chk("stall hold vld", wr_vld, 1);
      stall_prev = wr_vld && !wr_rdy;
      if (r_en) begin
        if (exp_raddr.size() == 0) unexpected("r_en");
        else chk("r_addr", r_addr, exp_raddr.pop_front());
      end
      if (start_dma) begin
        if (exp_cmd.size() == 0) unexpected("start_dma");
        else chk("dma cmd {trans,addr}", {num_trans, start_addr}, exp_cmd.pop_front());
      end
      if (ap_done) done_seen++;
    end
  end

  task automatic run_cmd(input int nw, input int idx, input logic [31:0] base, input bit early,
                         input logic [17:0] x_trans, input logic [31:0] x_addr);
    int n;
    exp_done++;
    if (nw > 0) begin
      exp_cmd.push_back({x_trans, x_addr});
      for (int w = 0; w < nw; w++) begin
        exp_raddr.push_back(5'(w));
        for (int b = 0; b < 4; b++) exp_beats.push_back(slice(w, b));
      end
    end
    num_words     = 6'(nw);
    dst_idx       = 9'(idx);
    dst_base_addr = base;
    ap_start      = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    if (nw == 0) begin
      @(negedge clk);
      chk("zero-word done", ap_done, 1);
      @(negedge clk);
      chk("zero-word done width", ap_done, 0);
      return;
    end
    if (early) begin
      n = 0;
      while (!wr_vld && n < 100) begin
        @(posedge clk);
        #2;
        n++;
      end
      chk("send reached", wr_vld, 1);
      done_i = 1'b1;
      @(posedge clk);
      #1 done_i = 1'b0;
    end
    n = 0;
    while (exp_beats.size() != 0 && n < 40 * nw + 50) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("beats drained", exp_beats.size(), 0);
    if (!early) done_i = 1'b1;
    @(negedge clk);
    chk("done not early", ap_done, 0);
    @(posedge clk);
    #1 done_i = 1'b0;
    @(negedge clk);
    chk("done pulse", ap_done, 1);
    @(negedge clk);
    chk("done width", ap_done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    for (int w = 0; w < 32; w++)
      for (int b = 0; b < 4; b++) mem[w][b*32 +: 32] = slice(w, b);
    r_data = '0;
    rstn = 1'b0;
    ap_start = 1'b0;
    done_i = 1'b0;
    num_words = '0;
    dst_idx = '0;
    dst_base_addr = '0;
    @(negedge clk);
    chk_idle("reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_cmd(1, 0, 32'h1000, 1'b0, 18'd4, 32'h1000);
    run_cmd(3, 2, 32'h0, 1'b0, 18'd12, 32'h60);
    rdy_toggle = 1'b1;
    run_cmd(2, 3, 32'h4000, 1'b0, 18'd8, 32'h4060);
    rdy_toggle = 1'b0;
    run_cmd(0, 5, 32'h8000, 1'b0, 18'd0, 32'h0);
    run_cmd(2, 1, 32'h100, 1'b1, 18'd8, 32'h120);
    // Full SRAM with an address that wraps past 2^32.
    run_cmd(32, 511, 32'hFFFF_F000, 1'b0, 18'd128, 32'h0003_EE00);

    // Abort a command mid-stream with reset.
    exp_cmd.push_back({18'd8, 32'h2020});
    for (int w = 0; w < 2; w++) begin
      exp_raddr.push_back(5'(w));
      for (int b = 0; b < 4; b++) exp_beats.push_back(slice(w, b));
    end
    num_words = 6'd2;
    dst_idx = 9'd1;
    dst_base_addr = 32'h2000;
    ap_start = 1'b1;
    @(posedge clk);
    #1 ap_start = 1'b0;
    for (int n = 0; n < 100 && !wr_vld; n++) begin
      @(posedge clk);
      #2;
    end
    chk("send before reset", wr_vld, 1);
    @(posedge clk);
    #1 rstn = 1'b0;
    exp_beats.delete();
    exp_raddr.delete();
    @(negedge clk);
    chk_idle("mid-send reset");
    @(posedge clk);
    #1 rstn = 1'b1;
    done_i = 1'b1;
    @(posedge clk);
    #1 done_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("stale done ignored", done_seen, exp_done);
    @(posedge clk);
    #1;
    run_cmd(1, 0, 32'h1000, 1'b0, 18'd4, 32'h1000);

    repeat (5) @(negedge clk);
    chk("leftover beats", exp_beats.size(), 0);
    chk("leftover reads", exp_raddr.size(), 0);
    chk("leftover cmds", exp_cmd.size(), 0);
    chk("ap_done count", done_seen, exp_done);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ofmap_storer.md
OFMAP_STORER -- requirements
Module: ofmap_storer

Interface
REQ-001 SHALL have parameter AXI_WIDTH_AD, default 32, meaning DRAM address width.
REQ-002 SHALL have parameter AXI_WIDTH_DA, default 32, meaning DMA data beat width.
REQ-003 SHALL have parameter BITS_TRANS, default 18, meaning DMA transfer-count width.
REQ-004 SHALL have parameter OUT_SRAM_ADDRESS, default 5, meaning output-SRAM address width.
REQ-005 SHALL have parameter DIN_WIDTH, default 16*8, meaning output-SRAM word width; BEATS = DIN_WIDTH/AXI_WIDTH_DA (default 4).
REQ-006 SHALL have clk  input  1  the single clock.
REQ-007 SHALL have rstn  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have ap_start  input  1  start request; ap_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have num_words  input  OUT_SRAM_ADDRESS+1  count of SRAM words to store (0..2^OUT_SRAM_ADDRESS).
REQ-010 SHALL have dst_idx  input  9  block index; dst_base_addr  input  AXI_WIDTH_DA  DRAM base address.
REQ-011 SHALL have r_en  output  1, r_addr  output  OUT_SRAM_ADDRESS, r_data  input  DIN_WIDTH  output-SRAM read port.
REQ-012 SHALL have start_dma  output  1, num_trans  output  BITS_TRANS, start_addr  output  AXI_WIDTH_AD  DMA write command.
REQ-013 SHALL have wr_data  output  AXI_WIDTH_DA, wr_vld  output  1, wr_rdy  input  1  DMA write beat stream.
REQ-014 SHALL have done_i  input  1  DMA write-complete pulse.

Function
REQ-015 SHALL implement states IDLE, FETCH, WAIT, SEND, DMA_WAIT.
REQ-016 SHALL, in IDLE with ap_start=1 and num_words>0, latch num_words, go to FETCH, and drive start_dma=1 for exactly one cycle.
REQ-017 SHALL, with start_dma, drive num_trans=num_words*BEATS and start_addr=dst_base_addr+4*BEATS*num_words*dst_idx, held until the next command.
REQ-018 SHALL, in IDLE with ap_start=1 and num_words=0, pulse ap_done next cycle, with no start_dma and no SRAM reads.
REQ-019 SHALL ignore ap_start outside IDLE.
REQ-020 SHALL, in FETCH, drive r_en=1 for one cycle at r_addr=word counter (starting 0), then enter WAIT.
REQ-021 SHALL treat r_data as valid the cycle after r_en; in WAIT it SHALL load r_data into the shift buffer and enter SEND.
REQ-022 SHALL, in SEND, hold wr_vld=1 with wr_data = current 32-bit slice, least-significant slice first.
REQ-023 SHALL count a beat only when wr_vld and wr_rdy are both 1; wr_data and wr_vld SHALL stay stable while wr_rdy=0.
REQ-024 SHALL, after beat BEATS of a word, deassert wr_vld, increment the word counter, and return to FETCH if words remain, else enter DMA_WAIT.
REQ-025 SHALL, in DMA_WAIT on done_i (or a done_i latched earlier in the command), pulse ap_done for one cycle and return to IDLE.
REQ-026 SHALL latch a done_i seen in FETCH/WAIT/SEND as sticky and clear it on return to IDLE; done_i in IDLE SHALL be ignored.
REQ-027 SHALL keep r_en=0, wr_vld=0, start_dma=0, ap_done=0 whenever not explicitly asserted above.
REQ-028 SHALL compute num_trans and start_addr with truncation to their port widths, with no saturation.

Reset
REQ-029 SHALL, on rstn=0 at any time, enter IDLE immediately and force all outputs to 0, clear counters, buffer and sticky done.
REQ-030 SHALL, after reset mid-command, ignore that command's remaining wr_rdy/done_i until the next ap_start.

Verification
REQ-031 SHALL cover: num_words=1, dst_idx=0, base=0x1000, wr_rdy=1 -> one start_dma, num_trans=4, start_addr=0x1000, 4 beats LS slice first, ap_done one cycle after done_i.
REQ-032 SHALL cover: num_words=3, dst_idx=2, base=0x0 -> num_trans=12, start_addr=0x60, r_addr sequence 0,1,2, 12 beats in order.
REQ-033 SHALL cover: wr_rdy toggling 1,0,0,1 randomly -> no beat lost or duplicated, wr_data stable while wr_rdy=0.
REQ-034 SHALL cover: num_words=0 -> ap_done pulse, no start_dma, no r_en.
REQ-035 SHALL cover: done_i pulsed during SEND, then beats finish -> ap_done one cycle after entering DMA_WAIT.
REQ-036 SHALL cover: rstn low mid-SEND, then ap_start again -> all outputs 0 during reset, fresh command starts at r_addr=0.
